clip_round_n: RTL and testbench

- Multi-lane, pipelined round/shift/saturate stage for the FME interpolation datapath.
- Takes signed filter accumulations (half/quarter-pel taps), applies an optional rounding offset and a run-time arithmetic right shift, then clamps each lane to an unsigned pixel range.
- Carries a valid flag alongside the data and keeps saturation statistics for filter tuning.
- Sits between the interpolation filter array and the SAD/cost unit.

---
 rtl/clip_round_n.sv | 136 +++++++++++++
 tb/tb_clip_round_n.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/clip_round_n.sv
// clip_round_n: two-stage round / arithmetic-shift / unsigned-clamp for FME interpolation.
// Stage 1 adds an optional rounding offset and shifts; stage 2 clamps to the pixel range
// and flags lanes that saturated. Saturation counts track stage-2 beats as they retire.
module clip_round_n #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned IN_WIDTH  = 11,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         clear_stats,
  input  logic                         in_valid,
  input  logic [LANES*IN_WIDTH-1:0]    in_data,
  input  logic [2:0]                   shift,
  input  logic                         round_en,
  output logic                         out_valid,
  output logic [LANES*OUT_WIDTH-1:0]   out_data,
  output logic [CNT_WIDTH-1:0]         sat_hi_count,
  output logic [CNT_WIDTH-1:0]         sat_lo_count
);

  // One extra bit so input plus offset can never overflow.
  localparam int unsigned SumW = IN_WIDTH + 1;
  localparam logic signed [SumW-1:0] MaxOut = SumW'((2 ** OUT_WIDTH) - 1);

  logic        [SumW-1:0] offset;
  logic signed [SumW-1:0] sum_s   [LANES];
  logic signed [SumW-1:0] s1_d    [LANES];
  logic signed [SumW-1:0] s1_data_q [LANES];
  logic                   s1_valid_q;

  logic [LANES*OUT_WIDTH-1:0] clip_data;
  logic [LANES-1:0]           hi_flag;
  logic [LANES-1:0]           lo_flag;

  logic                 out_valid_q;
  logic [LANES*OUT_WIDTH-1:0] out_data_q;
  logic [CNT_WIDTH-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_WIDTH-1:0] lo_cnt_q, lo_cnt_d;
  logic [CNT_WIDTH:0]   hi_sum, lo_sum;

  // Stage 1 datapath: sign-extend, add rounding offset, arithmetic shift (floor).
  always_comb begin
    offset = '0;
    if (round_en && (shift != 3'd0)) begin
      offset = SumW'(1) << (shift - 3'd1);
    end
    for (int k = 0; k < LANES; k++) begin
      sum_s[k] = $signed({in_data[k*IN_WIDTH + IN_WIDTH - 1], in_data[k*IN_WIDTH +: IN_WIDTH]})
               + $signed(offset);
      s1_d[k]  = sum_s[k] >>> shift;
    end
  end

  // Stage 1 registers: valid always advances, data only on valid beats.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        s1_data_q[k] <= '0;
      end
    end else if (enable) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < LANES; k++) begin
          s1_data_q[k] <= s1_d[k];
        end
      end
    end
  end

  // Stage 2 datapath: clamp each lane to [0, 2^OUT_WIDTH-1] and flag saturation.
  always_comb begin
    clip_data = '0;
    hi_flag   = '0;
    lo_flag   = '0;
    for (int k = 0; k < LANES; k++) begin
      if (s1_data_q[k][SumW-1]) begin
        lo_flag[k]                                = 1'b1;
        clip_data[k*OUT_WIDTH +: OUT_WIDTH]       = '0;
      end else if (s1_data_q[k] > MaxOut) begin
        hi_flag[k]                                = 1'b1;
        clip_data[k*OUT_WIDTH +: OUT_WIDTH]       = '1;
      end else begin
        clip_data[k*OUT_WIDTH +: OUT_WIDTH]       = s1_data_q[k][OUT_WIDTH-1:0];
      end
    end
  end

  // Stage 2 registers: out_data holds the last valid beat across bubbles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (enable) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= clip_data;
      end
    end
  end

  // Counter next-state: add popcount of flags with a carry bit, saturate on carry.
  always_comb begin
    hi_sum = {1'b0, hi_cnt_q};
    lo_sum = {1'b0, lo_cnt_q};
    for (int k = 0; k < LANES; k++) begin
      hi_sum = hi_sum + {{CNT_WIDTH{1'b0}}, hi_flag[k]};
      lo_sum = lo_sum + {{CNT_WIDTH{1'b0}}, lo_flag[k]};
    end
    hi_cnt_d = hi_sum[CNT_WIDTH] ? '1 : hi_sum[CNT_WIDTH-1:0];
    lo_cnt_d = lo_sum[CNT_WIDTH] ? '1 : lo_sum[CNT_WIDTH-1:0];
  end

  // Saturation counters: clear wins over increment and ignores enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
    end else if (clear_stats) begin
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
    end else if (enable && s1_valid_q) begin
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign sat_hi_count = hi_cnt_q;
  assign sat_lo_count = lo_cnt_q;

endmodule

// File: tb/tb_clip_round_n.sv
// Directed bench for clip_round_n with 4-bit counters so saturation is reachable.
module tb_clip_round_n;

  localparam int L  = 4;
  localparam int IW = 11;
  localparam int OW = 8;
  localparam int CW = 4;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            enable;
  logic            clear_stats;
  logic            in_valid;
  logic [L*IW-1:0] in_data;
  logic [2:0]      shift;
  logic            round_en;
  logic            out_valid;
  logic [L*OW-1:0] out_data;
  logic [CW-1:0]   sat_hi_count;
  logic [CW-1:0]   sat_lo_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  clip_round_n #(
    .LANES     (L),
    .IN_WIDTH  (IW),
    .OUT_WIDTH (OW),
    .CNT_WIDTH (CW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .clear_stats  (clear_stats),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .shift        (shift),
    .round_en     (round_en),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .sat_hi_count (sat_hi_count),
    .sat_lo_count (sat_lo_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sh, input logic rnd,
                       input int l0, input int l1, input int l2, input int l3);
    in_valid = v;
    shift    = sh;
    round_en = rnd;
    in_data  = {IW'(l3), IW'(l2), IW'(l1), IW'(l0)};
  endtask

  function automatic logic [L*OW-1:0] pk(input int o0, input int o1, input int o2, input int o3);
    return {OW'(o3), OW'(o2), OW'(o1), OW'(o0)};
  endfunction

  task automatic test_reset();
    reset_n = 1'b1; enable = 1'b0; clear_stats = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    n_cmp++; if (sat_hi_count !== '0) begin n_fail++; $display("FAIL reset_hi got %0d want 0", sat_hi_count); end
    n_cmp++; if (sat_lo_count !== '0) begin n_fail++; $display("FAIL reset_lo got %0d want 0", sat_lo_count); end
    @(posedge clock);
    @(posedge clock);
    #3 reset_n = 1'b1;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    drive(1'b1, 3'd0, 1'b0, -1, 255, 256, 100);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early got %0b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_data !== pk(0, 255, 255, 100)) begin n_fail++; $display("FAIL basic_data got %h want %h", out_data, pk(0, 255, 255, 100)); end
    n_cmp++; if (sat_hi_count !== 4'd1) begin n_fail++; $display("FAIL basic_hi got %0d want 1", sat_hi_count); end
    n_cmp++; if (sat_lo_count !== 4'd1) begin n_fail++; $display("FAIL basic_lo got %0d want 1", sat_lo_count); end
  endtask

  task automatic test_round();
    drive(1'b1, 3'd5, 1'b1, 16, 15, -17, 1023);
    tick();
    drive(1'b1, 3'd5, 1'b0, 16, 15, -17, 1023);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL round_on_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_data !== pk(1, 0, 0, 32)) begin n_fail++; $display("FAIL round_on_data got %h want %h", out_data, pk(1, 0, 0, 32)); end
    n_cmp++; if (sat_lo_count !== 4'd2) begin n_fail++; $display("FAIL round_on_lo got %0d want 2", sat_lo_count); end
    tick();
    n_cmp++; if (out_data !== pk(0, 0, 0, 31)) begin n_fail++; $display("FAIL round_off_data got %h want %h", out_data, pk(0, 0, 0, 31)); end
    n_cmp++; if (sat_lo_count !== 4'd3) begin n_fail++; $display("FAIL round_off_lo got %0d want 3", sat_lo_count); end
    n_cmp++; if (sat_hi_count !== 4'd1) begin n_fail++; $display("FAIL round_off_hi got %0d want 1", sat_hi_count); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== pk(0, 0, 0, 31)) begin n_fail++; $display("FAIL bubble_hold got %h want %h", out_data, pk(0, 0, 0, 31)); end
  endtask

  task automatic test_boundary();
    drive(1'b1, 3'd5, 1'b1, -1024, 1023, 0, -16);
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_data !== pk(0, 32, 0, 0)) begin n_fail++; $display("FAIL bound_data got %h want %h", out_data, pk(0, 32, 0, 0)); end
    n_cmp++; if (sat_lo_count !== 4'd4) begin n_fail++; $display("FAIL bound_lo got %0d want 4", sat_lo_count); end
    n_cmp++; if (sat_hi_count !== 4'd1) begin n_fail++; $display("FAIL bound_hi got %0d want 1", sat_hi_count); end
  endtask

  task automatic test_back_to_back_stall();
    // Per-edge schedule: enable, in_valid, beat index driven; expected out_valid, beat, count.
    logic en_t [11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    logic iv_t [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    int   bi_t [11] = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 0, 0};
    logic ev_t [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int   eb_t [11] = '{-1, 0, 1, 1, 1, 1, 2, 3, 4, 5, 5};
    int   ec_t [11] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 6};
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    n_cmp++; if (sat_hi_count !== 4'd0) begin n_fail++; $display("FAIL clear_hi got %0d want 0", sat_hi_count); end
    for (int e = 0; e < 11; e++) begin
      enable = en_t[e];
      drive(iv_t[e], 3'd0, 1'b0, 300, bi_t[e], 2 * bi_t[e], -5);
      tick();
      n_cmp++; if (out_valid !== ev_t[e]) begin n_fail++; $display("FAIL stall_valid edge %0d got %0b want %0b", e, out_valid, ev_t[e]); end
      if (eb_t[e] >= 0) begin
        n_cmp++; if (out_data !== pk(255, eb_t[e], 2 * eb_t[e], 0)) begin n_fail++; $display("FAIL stall_data edge %0d got %h want %h", e, out_data, pk(255, eb_t[e], 2 * eb_t[e], 0)); end
      end
      n_cmp++; if (sat_hi_count !== CW'(ec_t[e])) begin n_fail++; $display("FAIL stall_hi edge %0d got %0d want %0d", e, sat_hi_count, ec_t[e]); end
      n_cmp++; if (sat_lo_count !== CW'(ec_t[e])) begin n_fail++; $display("FAIL stall_lo edge %0d got %0d want %0d", e, sat_lo_count, ec_t[e]); end
    end
    enable = 1'b1;
  endtask

  task automatic test_saturate_clear();
    clear_stats = 1'b1;
    in_valid    = 1'b0;
    tick();
    clear_stats = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive(1'b1, 3'd0, 1'b0, 1000, 1000, 1000, 1000);
      tick();
    end
    drive(1'b1, 3'd0, 1'b0, 1000, 1000, 0, 0);
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (sat_hi_count !== 4'd14) begin n_fail++; $display("FAIL preload_hi got %0d want 14", sat_hi_count); end
    n_cmp++; if (sat_lo_count !== 4'd0) begin n_fail++; $display("FAIL preload_lo got %0d want 0", sat_lo_count); end
    drive(1'b1, 3'd0, 1'b0, 1000, 1000, 1000, 1000);
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (sat_hi_count !== 4'd15) begin n_fail++; $display("FAIL sat_hi got %0d want 15", sat_hi_count); end
    drive(1'b1, 3'd0, 1'b0, 1000, 1000, 0, 0);
    tick();
    in_valid    = 1'b0;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    n_cmp++; if (sat_hi_count !== 4'd0) begin n_fail++; $display("FAIL clear_prio got %0d want 0", sat_hi_count); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clear_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_data !== pk(255, 255, 0, 0)) begin n_fail++; $display("FAIL clear_data got %h want %h", out_data, pk(255, 255, 0, 0)); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 3'd0, 1'b0, 300, 1, 2, 3);
    tick();
    drive(1'b1, 3'd0, 1'b0, 4, 5, 6, 7);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (sat_hi_count !== 4'd1) begin n_fail++; $display("FAIL pre_reset_hi got %0d want 1", sat_hi_count); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL mid_reset_data got %h want 0", out_data); end
    n_cmp++; if (sat_hi_count !== '0) begin n_fail++; $display("FAIL mid_reset_hi got %0d want 0", sat_hi_count); end
    #2 reset_n = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ghost1_valid got %0b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ghost2_valid got %0b want 0", out_valid); end
    drive(1'b1, 3'd0, 1'b0, 10, 20, 30, 40);
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_data !== pk(10, 20, 30, 40)) begin n_fail++; $display("FAIL post_reset_data got %h want %h", out_data, pk(10, 20, 30, 40)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_boundary();
    test_back_to_back_stall();
    test_saturate_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
